fetch_stage: RTL and testbench

//  Instruction-fetch stage upstream of the combinational byte-addressed instruction memory.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_next_pc.sv | 33 +++
 rtl/fetch_stage.sv | 80 ++++++++
 tb/tb_fetch_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } if_id_t;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection and fetch address legality check (purely combinational).
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int MEM_BYTES = 256
) (
    input  logic [31:0] i_pc,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_target,
    input  logic        i_advance,
    input  logic        i_fault,
    output logic [31:0] o_next_pc,
    output logic        o_error
);

    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

    logic w_error;

    assign w_error = (i_pc > LAST_PC) || !is_aligned(i_pc);
    assign o_error = w_error;

    // A faulting PC is never advanced, so fetch stays parked on the bad address.
    always_comb begin
        o_next_pc = i_pc;
        if (i_redirect) begin
            o_next_pc = i_redirect_target & ~32'h0000_0003;
        end else if (!i_fault && !w_error && i_advance) begin
            o_next_pc = i_pc + 32'd4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register with
// valid/ready handshake, redirect handling and sticky fetch fault.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    input  logic        Redirect_Valid,
    input  logic [31:0] Redirect_Target,
    input  logic        IF_ID_Ready,
    output logic        IF_ID_Valid,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PC_Plus4,
    output logic        Fetch_Fault
);

    logic [31:0] r_pc;
    if_id_t      r_if_id;
    logic        r_valid;
    logic        r_fault;

    logic [31:0] w_next_pc;
    logic        w_error;
    logic        w_advance;

    // IF/ID slot is free when empty or being drained by decode this cycle.
    assign w_advance = !r_valid || IF_ID_Ready;

    fetch_next_pc #(
        .MEM_BYTES(MEM_BYTES)
    ) u_next_pc (
        .i_pc             (r_pc),
        .i_redirect       (Redirect_Valid),
        .i_redirect_target(Redirect_Target),
        .i_advance        (w_advance),
        .i_fault          (r_fault),
        .o_next_pc        (w_next_pc),
        .o_error          (w_error)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_if_id  <= '{instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd0};
            r_valid  <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            if (Redirect_Valid) begin
                r_valid <= 1'b0;
                if (!is_aligned(Redirect_Target)) begin
                    r_fault <= 1'b1;
                end
            end else if (r_fault || w_error) begin
                // Fetch halted: only let decode drain the word already captured.
                r_fault <= 1'b1;
                if (IF_ID_Ready) begin
                    r_valid <= 1'b0;
                end
            end else if (w_advance) begin
                r_if_id <= '{instr: Instruction, pc: r_pc, pc_plus4: r_pc + 32'd4};
                r_valid <= 1'b1;
            end
        end
    end

    assign Address           = r_pc;
    assign IF_ID_Valid       = r_valid;
    assign IF_ID_Instruction = r_if_id.instr;
    assign IF_ID_PC          = r_if_id.pc;
    assign IF_ID_PC_Plus4    = r_if_id.pc_plus4;
    assign Fetch_Fault       = r_fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage driving a byte-addressed instruction memory.
module tb_fetch_stage;

    localparam int MB = 256;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Address;
    logic [31:0] Instruction;
    logic        Redirect_Valid;
    logic [31:0] Redirect_Target;
    logic        IF_ID_Ready;
    logic        IF_ID_Valid;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_PC_Plus4;
    logic        Fetch_Fault;

    logic [7:0] mem [MB];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .MEM_BYTES(MB)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .Address          (Address),
        .Instruction      (Instruction),
        .Redirect_Valid   (Redirect_Valid),
        .Redirect_Target  (Redirect_Target),
        .IF_ID_Ready      (IF_ID_Ready),
        .IF_ID_Valid      (IF_ID_Valid),
        .IF_ID_Instruction(IF_ID_Instruction),
        .IF_ID_PC         (IF_ID_PC),
        .IF_ID_PC_Plus4   (IF_ID_PC_Plus4),
        .Fetch_Fault      (Fetch_Fault)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        int i;
        if (a > 32'(MB - 4)) return 32'hDEAD_BEEF;
        i = int'(a);
        return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
    endfunction

    assign Instruction = word_at(Address);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        Redirect_Valid = 1'b0;
        Redirect_Target = 32'd0;
        IF_ID_Ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        IF_ID_Ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        n_tests++;
        if (IF_ID_Valid !== 1'b0 || IF_ID_Instruction !== NOP || IF_ID_PC !== 32'd0 ||
            IF_ID_PC_Plus4 !== 32'd0 || Fetch_Fault !== 1'b0 || Address !== 32'd0) begin
            n_fail++;
            $display("FAIL reset: got v=%b ins=%h pc=%h pc4=%h flt=%b addr=%h want v=0 ins=%h pc=0 pc4=0 flt=0 addr=0",
                     IF_ID_Valid, IF_ID_Instruction, IF_ID_PC, IF_ID_PC_Plus4, Fetch_Fault, Address, NOP);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        do_reset();
        IF_ID_Ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if (IF_ID_Valid !== 1'b1 || IF_ID_PC !== 32'(4 * k) || IF_ID_PC_Plus4 !== 32'(4 * k + 4) ||
                IF_ID_Instruction !== word_at(32'(4 * k)) || Address !== 32'(4 * k + 4)) begin
                n_fail++;
                $display("FAIL seq[%0d]: got v=%b pc=%h pc4=%h ins=%h addr=%h want v=1 pc=%h pc4=%h ins=%h addr=%h",
                         k, IF_ID_Valid, IF_ID_PC, IF_ID_PC_Plus4, IF_ID_Instruction, Address,
                         4 * k, 4 * k + 4, word_at(32'(4 * k)), 4 * k + 4);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        IF_ID_Ready = 1'b1;
        tick();
        tick();
        IF_ID_Ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (IF_ID_Valid !== 1'b1 || IF_ID_PC !== 32'h4 || Address !== 32'h8 ||
                IF_ID_Instruction !== word_at(32'h4)) begin
                n_fail++;
                $display("FAIL stall[%0d]: got v=%b pc=%h addr=%h ins=%h want v=1 pc=4 addr=8 ins=%h",
                         k, IF_ID_Valid, IF_ID_PC, Address, IF_ID_Instruction, word_at(32'h4));
            end
        end
        IF_ID_Ready = 1'b1;
        tick();
        n_tests++;
        if (IF_ID_Valid !== 1'b1 || IF_ID_PC !== 32'h8 || IF_ID_Instruction !== word_at(32'h8) ||
            Address !== 32'hC) begin
            n_fail++;
            $display("FAIL stall_release: got v=%b pc=%h ins=%h addr=%h want v=1 pc=8 ins=%h addr=c",
                     IF_ID_Valid, IF_ID_PC, IF_ID_Instruction, Address, word_at(32'h8));
        end
    endtask

    task automatic test_redirect();
        do_reset();
        IF_ID_Ready = 1'b1;
        tick();
        tick();
        IF_ID_Ready = 1'b0;
        Redirect_Valid = 1'b1;
        Redirect_Target = 32'h40;
        tick();
        Redirect_Valid = 1'b0;
        n_tests++;
        if (IF_ID_Valid !== 1'b0 || Address !== 32'h40 || Fetch_Fault !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_flush: got v=%b addr=%h flt=%b want v=0 addr=40 flt=0",
                     IF_ID_Valid, Address, Fetch_Fault);
        end
        tick();
        n_tests++;
        if (IF_ID_Valid !== 1'b1 || IF_ID_PC !== 32'h40 || IF_ID_Instruction !== word_at(32'h40) ||
            Address !== 32'h44) begin
            n_fail++;
            $display("FAIL redirect_fetch: got v=%b pc=%h ins=%h addr=%h want v=1 pc=40 ins=%h addr=44",
                     IF_ID_Valid, IF_ID_PC, IF_ID_Instruction, Address, word_at(32'h40));
        end
    endtask

    task automatic test_misaligned();
        int bad = 0;
        do_reset();
        IF_ID_Ready = 1'b1;
        tick();
        Redirect_Valid = 1'b1;
        Redirect_Target = 32'h42;
        tick();
        Redirect_Valid = 1'b0;
        n_tests++;
        if (Fetch_Fault !== 1'b1 || Address !== 32'h40 || IF_ID_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign: got flt=%b addr=%h v=%b want flt=1 addr=40 v=0",
                     Fetch_Fault, Address, IF_ID_Valid);
        end
        for (int k = 0; k < 10; k++) begin
            IF_ID_Ready = 1'($urandom_range(0, 1));
            tick();
            if (Fetch_Fault !== 1'b1 || Address !== 32'h40 || IF_ID_Valid !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL misalign_hold: got %0d bad cycles want 0 (flt=%b addr=%h v=%b)",
                     bad, Fetch_Fault, Address, IF_ID_Valid);
        end
        do_reset();
        n_tests++;
        if (Fetch_Fault !== 1'b0 || Address !== 32'h0) begin
            n_fail++;
            $display("FAIL fault_clear: got flt=%b addr=%h want flt=0 addr=0", Fetch_Fault, Address);
        end
    endtask

    task automatic test_end_of_mem();
        do_reset();
        IF_ID_Ready = 1'b1;
        Redirect_Valid = 1'b1;
        Redirect_Target = 32'(MB - 8);
        tick();
        Redirect_Valid = 1'b0;
        tick();
        tick();
        n_tests++;
        if (IF_ID_Valid !== 1'b1 || IF_ID_PC !== 32'(MB - 4) || IF_ID_Instruction !== word_at(32'(MB - 4)) ||
            Fetch_Fault !== 1'b0 || Address !== 32'(MB)) begin
            n_fail++;
            $display("FAIL last_word: got v=%b pc=%h ins=%h flt=%b addr=%h want v=1 pc=%h ins=%h flt=0 addr=%h",
                     IF_ID_Valid, IF_ID_PC, IF_ID_Instruction, Fetch_Fault, Address,
                     MB - 4, word_at(32'(MB - 4)), MB);
        end
        IF_ID_Ready = 1'b0;
        tick();
        n_tests++;
        if (Fetch_Fault !== 1'b1 || IF_ID_Valid !== 1'b1 || IF_ID_PC !== 32'(MB - 4)) begin
            n_fail++;
            $display("FAIL range_fault: got flt=%b v=%b pc=%h want flt=1 v=1 pc=%h",
                     Fetch_Fault, IF_ID_Valid, IF_ID_PC, MB - 4);
        end
        IF_ID_Ready = 1'b1;
        tick();
        n_tests++;
        if (Fetch_Fault !== 1'b1 || IF_ID_Valid !== 1'b0 || Address !== 32'(MB)) begin
            n_fail++;
            $display("FAIL range_drain: got flt=%b v=%b addr=%h want flt=1 v=0 addr=%h",
                     Fetch_Fault, IF_ID_Valid, Address, MB);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        IF_ID_Ready = 1'b1;
        tick();
        tick();
        IF_ID_Ready = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        n_tests++;
        if (IF_ID_Valid !== 1'b0 || IF_ID_Instruction !== NOP || Address !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_stall: got v=%b ins=%h addr=%h want v=0 ins=%h addr=0",
                     IF_ID_Valid, IF_ID_Instruction, Address, NOP);
        end
        rst_n = 1'b1;
    endtask

    // Reference model: expected architectural state per clock from the fetch rules.
    task automatic test_random();
        logic [31:0] m_pc, m_ins, m_ipc, m_ipc4, tgt;
        logic        m_v, m_flt, rdy, rdr, rst;
        int          bad = 0;
        int          beats = 0;
        do_reset();
        m_pc = 0; m_ins = NOP; m_ipc = 0; m_ipc4 = 0; m_v = 0; m_flt = 0;
        for (int c = 0; c < 600; c++) begin
            rdy = ($urandom_range(0, 9) < 7);
            rdr = !m_flt && ($urandom_range(0, 19) == 0);
            rst = m_flt ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 9))
                0:       tgt = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
                1:       tgt = 32'(MB + 4 * $urandom_range(0, 3));
                default: tgt = 32'($urandom_range(0, 63) * 4);
            endcase
            rst_n = !rst;
            IF_ID_Ready = rdy;
            Redirect_Valid = rdr;
            Redirect_Target = tgt;
            if (rst) begin
                m_pc = 0; m_ins = NOP; m_ipc = 0; m_ipc4 = 0; m_v = 0; m_flt = 0;
            end else if (rdr) begin
                m_v = 0;
                if (tgt % 4 != 0) m_flt = 1;
                m_pc = tgt - (tgt % 4);
            end else if (m_flt || m_pc > MB - 4 || m_pc % 4 != 0) begin
                m_flt = 1;
                if (rdy) m_v = 0;
            end else if (!m_v || rdy) begin
                m_ins = word_at(m_pc);
                m_ipc = m_pc;
                m_ipc4 = m_pc + 4;
                m_v = 1;
                m_pc = m_pc + 4;
                beats++;
            end
            tick();
            if (Address !== m_pc || IF_ID_Valid !== m_v || Fetch_Fault !== m_flt ||
                IF_ID_Instruction !== m_ins || IF_ID_PC !== m_ipc || IF_ID_PC_Plus4 !== m_ipc4) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL random[%0d]: got addr=%h v=%b flt=%b ins=%h pc=%h pc4=%h want addr=%h v=%b flt=%b ins=%h pc=%h pc4=%h",
                             c, Address, IF_ID_Valid, Fetch_Fault, IF_ID_Instruction, IF_ID_PC, IF_ID_PC_Plus4,
                             m_pc, m_v, m_flt, m_ins, m_ipc, m_ipc4);
            end
        end
        rst_n = 1'b1;
        Redirect_Valid = 1'b0;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL random_total: got %0d mismatching cycles want 0", bad);
        end
        n_tests++;
        if (beats < 50) begin
            n_fail++;
            $display("FAIL random_activity: got %0d captures want at least 50", beats);
        end
    endtask

    initial begin
        for (int i = 0; i < MB; i++) mem[i] = 8'($urandom);
        rst_n = 1'b0;
        Redirect_Valid = 1'b0;
        Redirect_Target = 32'd0;
        IF_ID_Ready = 1'b0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_misaligned();
        test_end_of_mem();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
